// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared constants and helpers for the N-lane memory stage.
//   LANE_W    : width of one instruction / data lane
//   RT_W      : width of one destination register index
//   OPC_STORE : major opcode (bits [31:26]) that marks a lane as a store
//   NOP_WORD  : instruction word injected into a lane for a bubble
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int          LANE_W    = 32;
    localparam int          RT_W      = 5;
    localparam logic [5:0]  OPC_STORE = 6'b010001;
    localparam logic [31:0] NOP_WORD  = {3'b111, 29'b0};

    // True when the lane's major opcode is the store opcode.
    function automatic logic is_store(input logic [LANE_W-1:0] word);
        return (word[LANE_W-1 -: 6] == OPC_STORE);
    endfunction

endpackage

// File: rtl/sdp_ram_lanes.sv
// -----------------------------------------------------------------------------
// sdp_ram_lanes
// Inferred simple-dual-port RAM, one LANE_W-bit column per lane.
// Write port A and read port B share the address across lanes; each lane has
// its own write enable. The read result is registered (1-cycle latency) and
// only updates while re is high. A same-edge write to the address being read
// is forwarded to the read register (write-first).
// Ports:
//   clk    in  1               clock
//   rstn   in  1               async active-low reset (clears read register only)
//   we     in  LANES           per-lane write enable
//   re     in  1               read register enable
//   addra  in  ADDR_W          write word address
//   dina   in  LANES*LANE_W    write data, lane-aligned
//   addrb  in  ADDR_W          read word address
//   doutb  out LANES*LANE_W    registered read data
// -----------------------------------------------------------------------------
module sdp_ram_lanes
    import mem_stage_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [LANES-1:0]          we,
    input  logic                      re,
    input  logic [ADDR_W-1:0]         addra,
    input  logic [LANES*LANE_W-1:0]   dina,
    input  logic [ADDR_W-1:0]         addrb,
    output logic [LANES*LANE_W-1:0]   doutb
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic same_addr_s;

    assign same_addr_s = (addra == addrb);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] mem_r [DEPTH];
        logic [LANE_W-1:0] dout_r;
        logic              bypass_s;

        // A lane only forwards its own write; non-writing lanes read the array.
        assign bypass_s = we[i] & same_addr_s;

        // Write port: array contents are deliberately not reset.
        always_ff @(posedge clk) begin
            if (we[i]) begin
                mem_r[addra] <= dina[i*LANE_W +: LANE_W];
            end
        end

        // Registered read port with write-first forwarding.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                dout_r <= '0;
            end else if (re) begin
                dout_r <= bypass_s ? dina[i*LANE_W +: LANE_W] : mem_r[addrb];
            end
        end

        assign doutb[i*LANE_W +: LANE_W] = dout_r;
    end

endmodule

// File: rtl/mem_stage_nlane.sv
// -----------------------------------------------------------------------------
// mem_stage_nlane
// Memory stage for the N-lane in-order core. Decodes a per-lane store enable
// from each lane's opcode, drives the lane RAM, and registers the bundle and
// its writeback tags toward writeback. Load data leaves the RAM aligned with
// the registered bundle.
// Stall handling:
//   STALL_MODE=0 : interlock turns this cycle into a bubble (RAM read still runs)
//   STALL_MODE=1 : interlock freezes every output, including load data
// Ports:
//   clk, rstn                 clock, async active-low reset
//   interlock                 downstream/hazard stall
//   memory_used               bundle valid for this stage
//   inst                      LANES*32 bundle, lane i = inst[32i+31:32i]
//   addra, dina               store word address / lane-aligned store data
//   addrb                     load word address
//   rt, rt_flag, tdata        per-lane dest reg, writeback enable, ALU result
//   inst_to_the_next ..       registered bundle and tags
//   mem_doutb                 load data, aligned with inst_to_the_next
// -----------------------------------------------------------------------------
module mem_stage_nlane
    import mem_stage_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int ADDR_W     = 10,
    parameter int STALL_MODE = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      interlock,
    input  logic                      memory_used,
    input  logic [LANES*LANE_W-1:0]   inst,
    input  logic [ADDR_W-1:0]         addra,
    input  logic [LANES*LANE_W-1:0]   dina,
    input  logic [ADDR_W-1:0]         addrb,
    input  logic [LANES*RT_W-1:0]     rt,
    input  logic [LANES-1:0]          rt_flag,
    input  logic [LANES*LANE_W-1:0]   tdata,
    output logic [LANES*LANE_W-1:0]   inst_to_the_next,
    output logic [LANES*RT_W-1:0]     rt_to_the_next,
    output logic [LANES-1:0]          rt_flag_to_the_next,
    output logic [LANES*LANE_W-1:0]   tdata_to_the_next,
    output logic [LANES*LANE_W-1:0]   mem_doutb
);

    localparam logic                    HOLD_EN    = (STALL_MODE == 32'sd1);
    localparam logic [LANES*LANE_W-1:0] NOP_BUNDLE = {LANES{NOP_WORD}};

    logic             advance_s;
    logic             hold_s;
    logic             re_s;
    logic [LANES-1:0] we_s;

    assign advance_s = memory_used & ~interlock;
    assign hold_s    = HOLD_EN & interlock;
    // In hold mode the read register must freeze too, otherwise load data
    // would drift away from the frozen bundle.
    assign re_s      = ~hold_s;

    // Store decode: writes only happen for a bundle that actually advances.
    always_comb begin
        we_s = '0;
        for (int i = 0; i < LANES; i++) begin
            we_s[i] = advance_s & is_store(inst[i*LANE_W +: LANE_W]);
        end
    end

    sdp_ram_lanes #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we_s),
        .re    (re_s),
        .addra (addra),
        .dina  (dina),
        .addrb (addrb),
        .doutb (mem_doutb)
    );

    // Pipeline registers: hold wins over advance, anything else is a bubble
    // (rt and tdata are left as-is in a bubble since rt_flag masks them).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inst_to_the_next    <= NOP_BUNDLE;
            rt_to_the_next      <= '0;
            rt_flag_to_the_next <= '0;
            tdata_to_the_next   <= '0;
        end else if (hold_s) begin
            inst_to_the_next    <= inst_to_the_next;
            rt_to_the_next      <= rt_to_the_next;
            rt_flag_to_the_next <= rt_flag_to_the_next;
            tdata_to_the_next   <= tdata_to_the_next;
        end else if (advance_s) begin
            inst_to_the_next    <= inst;
            rt_to_the_next      <= rt;
            rt_flag_to_the_next <= rt_flag;
            tdata_to_the_next   <= tdata;
        end else begin
            inst_to_the_next    <= NOP_BUNDLE;
            rt_to_the_next      <= rt_to_the_next;
            rt_flag_to_the_next <= '0;
            tdata_to_the_next   <= tdata_to_the_next;
        end
    end

endmodule

// File: tb/tb_mem_stage_nlane.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_nlane
// Two instances share one stimulus stream: u_dut1 (hold-on-interlock) and
// u_dut0 (bubble-on-interlock). A behavioural model (array memory plus the
// expected registered outputs for each mode) is stepped on every clock edge;
// a single compare process checks both instances on every falling edge.
// Directed sequences pin the model with hand-computed literal values, then
// a randomized stream runs against the model.
// -----------------------------------------------------------------------------
module tb_mem_stage_nlane;

    localparam int L  = 2;
    localparam int AW = 4;
    localparam int D  = 16;
    localparam logic [31:0]     NOPW = 32'hE000_0000;
    localparam logic [5:0]      OPS  = 6'b010001;
    localparam logic [L*32-1:0] NOPB = {L{NOPW}};

    logic            clk = 1'b0;
    logic            rstn, interlock, memory_used;
    logic [L*32-1:0] inst, dina, tdata;
    logic [AW-1:0]   addra, addrb;
    logic [L*5-1:0]  rt;
    logic [L-1:0]    rt_flag;

    logic [L*32-1:0] o1_inst, o1_tdata, o1_dout, o0_inst, o0_tdata, o0_dout;
    logic [L*5-1:0]  o1_rt, o0_rt;
    logic [L-1:0]    o1_flag, o0_flag;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // behavioural model state
    logic [31:0]     mem_m [L][D];
    bit              mem_k [L][D];
    logic [L*32-1:0] e_inst  [2];
    logic [L*5-1:0]  e_rt    [2];
    logic [L-1:0]    e_flag  [2];
    logic [L*32-1:0] e_tdata [2];
    logic [31:0]     e_dout  [2][L];
    bit              e_dk    [2][L];

    always #5 clk = ~clk;

    mem_stage_nlane #(.LANES(L), .ADDR_W(AW), .STALL_MODE(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .interlock(interlock), .memory_used(memory_used),
        .inst(inst), .addra(addra), .dina(dina), .addrb(addrb), .rt(rt),
        .rt_flag(rt_flag), .tdata(tdata), .inst_to_the_next(o1_inst),
        .rt_to_the_next(o1_rt), .rt_flag_to_the_next(o1_flag),
        .tdata_to_the_next(o1_tdata), .mem_doutb(o1_dout));

    mem_stage_nlane #(.LANES(L), .ADDR_W(AW), .STALL_MODE(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .interlock(interlock), .memory_used(memory_used),
        .inst(inst), .addra(addra), .dina(dina), .addrb(addrb), .rt(rt),
        .rt_flag(rt_flag), .tdata(tdata), .inst_to_the_next(o0_inst),
        .rt_to_the_next(o0_rt), .rt_flag_to_the_next(o0_flag),
        .tdata_to_the_next(o0_tdata), .mem_doutb(o0_dout));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            e_inst[m] = NOPB; e_rt[m] = '0; e_flag[m] = '0; e_tdata[m] = '0;
            for (int i = 0; i < L; i++) begin
                e_dout[m][i] = 32'h0; e_dk[m][i] = 1'b1;
            end
        end
    endtask

    // One clock edge of the stage, computed from the inputs present at the edge.
    task automatic model_step();
        logic        adv;
        logic        wr [L];
        logic [31:0] rd [L];
        bit          rk [L];
        if (!rstn) begin
            model_reset();
            return;
        end
        adv = memory_used & ~interlock;
        for (int i = 0; i < L; i++) begin
            wr[i] = adv && (inst[i*32+26 +: 6] == OPS);
            if (wr[i] && addra == addrb) begin
                rd[i] = dina[i*32 +: 32]; rk[i] = 1'b1;
            end else begin
                rd[i] = mem_m[i][addrb]; rk[i] = mem_k[i][addrb];
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (!(m == 1 && interlock)) begin
                if (adv) begin
                    e_inst[m] = inst; e_rt[m] = rt; e_flag[m] = rt_flag; e_tdata[m] = tdata;
                end else begin
                    e_inst[m] = NOPB; e_flag[m] = '0;
                end
                for (int i = 0; i < L; i++) begin
                    e_dout[m][i] = rd[i]; e_dk[m][i] = rk[i];
                end
            end
        end
        for (int i = 0; i < L; i++) begin
            if (wr[i]) begin
                mem_m[i][addra] = dina[i*32 +: 32]; mem_k[i][addra] = 1'b1;
            end
        end
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("inst_m1",  o1_inst,        e_inst[1]);
            chk("rt_m1",    64'(o1_rt),     64'(e_rt[1]));
            chk("flag_m1",  64'(o1_flag),   64'(e_flag[1]));
            chk("tdata_m1", o1_tdata,       e_tdata[1]);
            chk("inst_m0",  o0_inst,        e_inst[0]);
            chk("rt_m0",    64'(o0_rt),     64'(e_rt[0]));
            chk("flag_m0",  64'(o0_flag),   64'(e_flag[0]));
            chk("tdata_m0", o0_tdata,       e_tdata[0]);
            for (int i = 0; i < L; i++) begin
                if (e_dk[1][i]) chk("dout_m1", 64'(o1_dout[i*32 +: 32]), 64'(e_dout[1][i]));
                if (e_dk[0][i]) chk("dout_m0", 64'(o0_dout[i*32 +: 32]), 64'(e_dout[0][i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] st_word(input logic [25:0] low);
        return {OPS, low};
    endfunction

    task automatic set_idle();
        memory_used = 1'b0; interlock = 1'b0; inst = NOPB; dina = '0;
        addra = '0; addrb = '0; rt = '0; rt_flag = '0; tdata = '0;
    endtask

    task automatic do_store(input int lane, input logic [AW-1:0] a, input logic [31:0] d);
        memory_used = 1'b1; interlock = 1'b0; inst = '0; dina = '0;
        inst[lane*32 +: 32] = st_word(26'h0);
        dina[lane*32 +: 32] = d;
        addra = a; addrb = '0;
        tick();
    endtask

    logic [L*32-1:0] bx, by;

    initial begin
        rstn = 1'b0;
        set_idle();
        model_reset();
        repeat (2) tick();
        chk("rst_inst",  o1_inst,          64'hE0000000E0000000);
        chk("rst_dout",  o1_dout,          64'h0);
        chk("rst_flag",  64'(o0_flag),     64'h0);
        cmp_en = 1'b1;
        rstn = 1'b1;
        tick();

        // 1: store then load
        memory_used = 1'b1; inst = {32'h0, st_word(26'h0)};
        addra = 4'd5; dina = {32'h0, 32'hDEADBEEF}; addrb = 4'd0;
        rt = 10'h2A1; rt_flag = 2'b10; tdata = 64'h1111_2222_3333_4444;
        tick();
        inst = '0; addrb = 4'd5;
        tick();
        chk("t1_load_m1", 64'(o1_dout[31:0]), 64'hDEADBEEF);
        chk("t1_load_m0", 64'(o0_dout[31:0]), 64'hDEADBEEF);

        // 2: same-cycle write/read, only lane1 writes
        do_store(0, 4'd7, 32'hA5A5A5A5);
        memory_used = 1'b1; inst = {st_word(26'h0), 32'h0};
        addra = 4'd7; addrb = 4'd7; dina = {32'h12345678, 32'hFFFFFFFF};
        tick();
        chk("t2_bypass_l1", 64'(o1_dout[63:32]), 64'h12345678);
        chk("t2_old_l0",    64'(o1_dout[31:0]),  64'hA5A5A5A5);

        // 3/4: three-cycle interlock with a store bundle waiting
        do_store(0, 4'd9, 32'h22222222);
        bx = {32'h0400_0001, 32'h0800_0002};
        memory_used = 1'b1; inst = bx; rt_flag = 2'b11; rt = 10'h155;
        tdata = 64'hCAFE_0000_0000_BEEF; addrb = 4'd0;
        tick();
        by = {32'h0C00_0003, st_word(26'h4)};
        inst = by; addra = 4'd9; dina = {32'h0, 32'h11111111}; addrb = 4'd9;
        rt_flag = 2'b01; interlock = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t3_hold_inst", o1_inst,         bx);
            chk("t3_hold_flag", 64'(o1_flag),    64'h3);
            chk("t4_bubble",    o0_inst,         64'hE0000000E0000000);
            chk("t4_flag",      64'(o0_flag),    64'h0);
            chk("t3_nostore",   64'(o0_dout[31:0]), 64'h22222222);
        end
        interlock = 1'b0;
        tick();
        chk("t3_release",   o1_inst,              by);
        chk("t3_store_byp", 64'(o1_dout[31:0]),   64'h11111111);

        // 5: invalid bundle carrying a store opcode
        do_store(0, 4'd3, 32'h33333333);
        memory_used = 1'b0; inst = {32'h0, st_word(26'h0)};
        addra = 4'd3; dina = {32'h0, 32'hBAD0BAD0}; addrb = 4'd3;
        tick();
        chk("t5_bubble", o1_inst,            64'hE0000000E0000000);
        chk("t5_flag",   64'(o1_flag),       64'h0);
        chk("t5_read",   64'(o0_dout[31:0]), 64'h33333333);
        memory_used = 1'b1; inst = '0;
        tick();
        chk("t5_unchanged", 64'(o1_dout[31:0]), 64'h33333333);

        // 6: reset mid-stall
        inst = {32'h0400_0009, 32'h0400_0008}; rt_flag = 2'b11; interlock = 1'b1;
        tick();
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_inst", o1_inst,       64'hE0000000E0000000);
        chk("t6_rst_dout", o1_dout,       64'h0);
        chk("t6_rst_flag", 64'(o1_flag),  64'h0);
        chk("t6_rst_m0",   o0_inst,       64'hE0000000E0000000);
        tick();
        rstn = 1'b1; interlock = 1'b0; memory_used = 1'b1; inst = '0; addrb = 4'd5;
        tick();
        chk("t6_ram_kept", 64'(o1_dout[31:0]), 64'hDEADBEEF);

        // randomized stream
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < L; i++) begin
                logic [5:0] op;
                op = ($urandom_range(0, 2) == 0) ? OPS : 6'($urandom);
                inst[i*32 +: 32] = {op, 26'($urandom)};
                dina[i*32 +: 32] = $urandom;
                tdata[i*32 +: 32] = $urandom;
            end
            rt          = 10'($urandom);
            rt_flag     = 2'($urandom);
            memory_used = ($urandom_range(0, 9) != 0);
            interlock   = ($urandom_range(0, 3) == 0);
            addra       = 4'($urandom);
            addrb       = 4'($urandom);
            tick();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
